pet_input_conditioner: RTL

Front end that produces the stimulus side of the pet state machine's interface: `feeding`, `healing`, `light_out` and `echo_sig`. It synchronizes raw board inputs (two push buttons, a light sensor comparator, an ultrasonic echo pin) and debounces them. It emits single-cycle feeding/healing pulses and a filtered light level. It also runs the ultrasonic trigger/measure cycle that yields a presence flag. Outputs connect directly to the same-named inputs of the state machine, on the same clock.

---
 rtl/pet_input_conditioner.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pet_input_conditioner.sv
// Stimulus front end for the pet state machine: synchronizes and filters the
// buttons and light sensor, and runs the ultrasonic trigger/measure cycle.
module pet_debounce #(
  parameter int unsigned N     = 4,
  parameter bit          PULSE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic out_o
);
  logic        s1_q, s2_q, stable_q, rise_q;
  logic [15:0] cnt_q;
  logic        differ, accept;

  assign differ = (s2_q != stable_q);
  assign accept = differ && (cnt_q == 16'(N - 1));
  // Pulse paths report the registered rising edge of the accepted level.
  assign out_o  = PULSE ? rise_q : stable_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      rise_q <= accept && s2_q;
      if (accept) begin
        stable_q <= s2_q;
        cnt_q    <= '0;
      end else if (differ) begin
        cnt_q <= cnt_q + 16'd1;
      end else begin
        cnt_q <= '0;
      end
    end
  end
endmodule

module pet_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES     = 4,
  parameter int unsigned LIGHT_FILTER_CYCLES = 8,
  parameter int unsigned MEAS_PERIOD         = 200,
  parameter int unsigned TRIG_CYCLES         = 10,
  parameter int unsigned ECHO_TIMEOUT        = 1000,
  parameter int unsigned NEAR_THRESHOLD      = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_feed,
  input  logic        btn_heal,
  input  logic        light_raw,
  input  logic        echo_in,
  output logic        trig_out,
  output logic        feeding,
  output logic        healing,
  output logic        light_out,
  output logic        echo_sig,
  output logic [15:0] dist_cnt
);
  localparam int NPATH = 3;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLD} us_state_e;

  logic [NPATH-1:0] raw, cond;
  assign raw = {light_raw, btn_heal, btn_feed};

  // Paths 0/1 are buttons (pulse on accepted press), path 2 is the light level.
  for (genvar i = 0; i < NPATH; i++) begin : g_path
    pet_debounce #(
      .N     ((i == 2) ? LIGHT_FILTER_CYCLES : DEBOUNCE_CYCLES),
      .PULSE (i != 2)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw_i (raw[i]),
      .out_o (cond[i])
    );
  end

  assign feeding   = cond[0];
  assign healing   = cond[1];
  assign light_out = cond[2];

  us_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d, dist_q, dist_d;
  logic        near_q, near_d;
  logic        echo_s1_q, echo_s2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dist_q    <= '0;
      near_q    <= 1'b0;
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dist_q    <= dist_d;
      near_q    <= near_d;
      echo_s1_q <= echo_in;
      echo_s2_q <= echo_s1_q;
    end
  end

  // cnt_q is shared: period/trigger/wait timer, and echo width in MEASURE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    near_d  = near_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_q == 16'(MEAS_PERIOD - 1)) begin
          state_d = TRIG;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      TRIG: begin
        if (cnt_q == 16'(TRIG_CYCLES - 1)) begin
          state_d = WAIT_ECHO;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      WAIT_ECHO: begin
        if (echo_s2_q) begin
          state_d = MEASURE;
          cnt_d   = 16'd1;
        end else if (cnt_q == 16'(ECHO_TIMEOUT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          dist_d  = 16'(ECHO_TIMEOUT);
          near_d  = 1'b0;
        end else cnt_d = cnt_q + 16'd1;
      end
      MEASURE: begin
        if (!echo_s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          dist_d  = cnt_q;
          near_d  = (32'(cnt_q) < NEAR_THRESHOLD);
        end else if (cnt_q == 16'(ECHO_TIMEOUT)) begin
          state_d = HOLD;
          cnt_d   = '0;
          dist_d  = 16'(ECHO_TIMEOUT);
          near_d  = 1'b0;
        end else cnt_d = cnt_q + 16'd1;
      end
      HOLD: begin
        if (!echo_s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign trig_out = (state_q == TRIG);
  assign echo_sig = near_q;
  assign dist_cnt = dist_q;
endmodule
